regfile_mp_sb: RTL and testbench

//   Parametrised multi-port GPR file with per-register pending-write scoreboard.

---
 rtl/regfile_mp_sb.sv | 108 ++++++++++
 tb/tb_regfile_mp_sb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port general-purpose register file with a per-register
// pending-write scoreboard.
//   - NR combinational read ports, two write ports (wr1 wins on address clash)
//   - register 0 reads as zero and is never busy
//   - busy_cnt tracks how many registers have a write pending
// Optional feature macro: RF_BYPASS_EN
//   defined   -> same-cycle write-through on rd_data, and rd_busy drops in the
//                cycle a write to that register is presented
//   undefined -> rd_data / rd_busy come purely from stored state
module regfile_mp_sb #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int NR    = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NR*AW-1:0]  rd_addr,
  output logic [NR*DW-1:0]  rd_data,
  output logic [NR-1:0]     rd_busy,
  input  logic              wr0_en,
  input  logic [AW-1:0]     wr0_addr,
  input  logic [DW-1:0]     wr0_data,
  input  logic              wr1_en,
  input  logic [AW-1:0]     wr1_addr,
  input  logic [DW-1:0]     wr1_data,
  input  logic              sb_set_en,
  input  logic [AW-1:0]     sb_set_addr,
  output logic [AW:0]       busy_cnt
);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [AW:0]      r_busy_cnt;

  logic [DEPTH-1:0] w_busy_nxt;
  logic [AW:0]      w_inc;
  logic [AW:0]      w_dec;
  logic [AW-1:0]    w_ra;

  // Storage: wr1 is applied after wr0 so it wins on a shared address; reg 0 never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) r_mem[r] <= '0;
    end else begin
      if (wr0_en && wr0_addr != '0) r_mem[wr0_addr] <= wr0_data;
      if (wr1_en && wr1_addr != '0) r_mem[wr1_addr] <= wr1_data;
    end
  end

  // Next busy vector: a new producer (set) beats a retiring write (clear) on the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 1; r < DEPTH; r++) begin
      if (sb_set_en && sb_set_addr == AW'(r))
        w_busy_nxt[r] = 1'b1;
      else if ((wr0_en && wr0_addr == AW'(r)) || (wr1_en && wr1_addr == AW'(r)))
        w_busy_nxt[r] = 1'b0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Counter deltas: at most one 0->1 flip (single set port), up to two 1->0 flips.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (sb_set_en && sb_set_addr != '0 && !r_busy[sb_set_addr]) w_inc = (AW+1)'(1);
    for (int r = 1; r < DEPTH; r++)
      if (r_busy[r] && !w_busy_nxt[r]) w_dec = w_dec + (AW+1)'(1);
  end

  // Scoreboard state and incrementally maintained busy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= r_busy_cnt + w_inc - w_dec;
    end
  end

  assign busy_cnt = r_busy_cnt;

  // Read ports: zero-latency lookup, optionally overlaid with same-cycle write-through.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    w_ra    = '0;
    for (int i = 0; i < NR; i++) begin
      w_ra               = rd_addr[i*AW +: AW];
      rd_data[i*DW +: DW] = r_mem[w_ra];
      rd_busy[i]         = r_busy[w_ra];
`ifdef RF_BYPASS_EN
      if (w_ra != '0) begin
        if (wr1_en && wr1_addr == w_ra)
          rd_data[i*DW +: DW] = wr1_data;
        else if (wr0_en && wr0_addr == w_ra)
          rd_data[i*DW +: DW] = wr0_data;
        if (((wr0_en && wr0_addr == w_ra) || (wr1_en && wr1_addr == w_ra)) &&
            !(sb_set_en && sb_set_addr == w_ra))
          rd_busy[i] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed testbench for regfile_mp_sb (DW=32, DEPTH=32, NR=2).
module tb_regfile_mp_sb;

  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int NR = 2;
  localparam int AW = 5;

  logic              clk;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr0_en;
  logic [AW-1:0]     wr0_addr;
  logic [DW-1:0]     wr0_data;
  logic              wr1_en;
  logic [AW-1:0]     wr1_addr;
  logic [DW-1:0]     wr1_data;
  logic              sb_set_en;
  logic [AW-1:0]     sb_set_addr;
  logic [AW:0]       busy_cnt;

  int n_pass;
  int n_total;

  regfile_mp_sb #(.DW(DW), .DEPTH(DEPTH), .NR(NR)) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .busy_cnt(busy_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge and move 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr0_en = 0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0;
    sb_set_en = 0; sb_set_addr = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1;
    rd_addr = '0;
    idle_inputs();
    tick();
    tick();
    reset = 0;

    // Reset state
    set_rd(5'd5, 5'd31);
    chk("reset_rd0", rd_data[31:0], 0);
    chk("reset_rd1", rd_data[63:32], 0);
    chk("reset_busy", rd_busy, 0);
    chk("reset_cnt", busy_cnt, 0);

    // 1: activity, then reset while inputs are active
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'h11;
    sb_set_en = 1; sb_set_addr = 6;
    tick();
    idle_inputs();
    set_rd(5'd5, 5'd6);
    chk("pre_rst_data", rd_data[31:0], 32'h11);
    chk("pre_rst_busy", rd_busy, 2'b10);
    chk("pre_rst_cnt", busy_cnt, 1);
    reset = 1;
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'h22;
    sb_set_en = 1; sb_set_addr = 7;
    tick();
    reset = 0;
    idle_inputs();
    set_rd(5'd5, 5'd7);
    chk("rst_data5", rd_data[31:0], 0);
    chk("rst_busy", rd_busy, 0);
    chk("rst_cnt", busy_cnt, 0);

    // 2: basic write / read, and writes to reg 0 ignored
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'h12345678;
    tick();
    idle_inputs();
    wr1_en = 1; wr1_addr = 0; wr1_data = 32'hFFFFFFFF;
    tick();
    idle_inputs();
    set_rd(5'd5, 5'd0);
    chk("wr_reg5", rd_data[31:0], 32'h12345678);
    chk("wr_reg0", rd_data[63:32], 0);

    // 3: same-address dual write, wr1 wins
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'hAAAA0000;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h5555FFFF;
    tick();
    idle_inputs();
    set_rd(5'd7, 5'd5);
    chk("dual_wr_reg7", rd_data[31:0], 32'h5555FFFF);
    chk("dual_wr_reg5", rd_data[63:32], 32'h12345678);

    // 4: scoreboard set / clear
    sb_set_en = 1; sb_set_addr = 3;
    tick();
    sb_set_addr = 9;
    tick();
    idle_inputs();
    set_rd(5'd3, 5'd9);
    chk("sb_cnt2", busy_cnt, 2);
    chk("sb_busy_3_9", rd_busy, 2'b11);
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'h33;
    tick();
    idle_inputs();
    set_rd(5'd3, 5'd9);
    chk("clr_cnt1", busy_cnt, 1);
    chk("clr_busy", rd_busy, 2'b10);
    chk("clr_data3", rd_data[31:0], 32'h33);
    sb_set_en = 1; sb_set_addr = 9;
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h99;
    tick();
    idle_inputs();
    set_rd(5'd9, 5'd3);
    chk("setwins_busy", rd_busy, 2'b01);
    chk("setwins_cnt", busy_cnt, 1);
    chk("setwins_data9", rd_data[31:0], 32'h99);

    // 5: set on reg 0 ignored; fill all nonzero registers
    sb_set_en = 1; sb_set_addr = 0;
    tick();
    idle_inputs();
    set_rd(5'd0, 5'd9);
    chk("set0_busy", rd_busy, 2'b10);
    chk("set0_cnt", busy_cnt, 1);
    for (int r = 1; r < DEPTH; r++) begin
      sb_set_en = 1; sb_set_addr = AW'(r);
      tick();
    end
    idle_inputs();
    set_rd(5'd1, 5'd31);
    chk("full_cnt", busy_cnt, 31);
    chk("full_busy", rd_busy, 2'b11);
    // Re-set of an already busy register leaves the count alone
    sb_set_en = 1; sb_set_addr = 31;
    tick();
    idle_inputs();
    #1;
    chk("reset_busy_cnt", busy_cnt, 31);
    // Two registers retire in one edge
    wr0_en = 1; wr0_addr = 10; wr0_data = 32'hA;
    wr1_en = 1; wr1_addr = 11; wr1_data = 32'hB;
    tick();
    idle_inputs();
    set_rd(5'd10, 5'd11);
    chk("dual_clr_cnt", busy_cnt, 29);
    chk("dual_clr_busy", rd_busy, 2'b00);
    chk("dual_clr_data", rd_data, {32'hB, 32'hA});

    // 6: same-cycle visibility of a write to busy reg 4 (stored value 0)
    rd_addr = {5'd0, 5'd4};
    wr0_en = 1; wr0_addr = 4; wr0_data = 32'hDEADBEEF;
    #1;
`ifdef RF_BYPASS_EN
    chk("byp_data", rd_data[31:0], 32'hDEADBEEF);
    chk("byp_busy", rd_busy[0], 1'b0);
`else
    chk("nobyp_data", rd_data[31:0], 32'h0);
    chk("nobyp_busy", rd_busy[0], 1'b1);
`endif
    tick();
    idle_inputs();
    #1;
    chk("post_wr4_data", rd_data[31:0], 32'hDEADBEEF);
    chk("post_wr4_busy", rd_busy[0], 1'b0);
    chk("post_wr4_cnt", busy_cnt, 28);

    // Reset mid-operation discards pending state
    reset = 1;
    tick();
    reset = 0;
    set_rd(5'd4, 5'd31);
    chk("final_rst_cnt", busy_cnt, 0);
    chk("final_rst_busy", rd_busy, 0);
    chk("final_rst_data", rd_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
